uart_tx_unit_sc: RTL and testbench

Buffered UART transmitter on a single clock domain: the core writes bytes into an internal FIFO, and a serializer drains the FIFO onto `txd` as 8N1 frames, LSB first. It is the transmit counterpart of the existing receive path and shares its baud parameterisation. It sits between the CPU's MMIO/IO-port logic and the board TX pin.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 64 ++++++
 rtl/uart_tx_unit_sc.sv | 172 +++++++++++++++++
 tb/tb_uart_tx_unit_sc.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and helpers: transmit state encoding,
//               data width and baud-period helper. Used by the transmit
//               path (uart_tx_unit_sc); optional parity via
//               UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  // One bit period in clocks, derived from the half-bit setting.
  function automatic int bit_clks(input int clk_per_half_bit);
    return 2 * clk_per_half_bit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock circular-buffer FIFO. DEPTH must be a power of
//               two (>= 2) so the pointers wrap naturally. full/empty come
//               from the registered occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // Full is judged on the registered count, so a push while full is dropped
  // even when a pop happens in the same cycle.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  assign full  = (r_count == (AW + 1)'(DEPTH));
  assign empty = (r_count == '0);
  assign dout  = r_mem[r_rd_ptr];

  // Pointer and occupancy bookkeeping; reset discards contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; the array itself needs no reset.
  always_ff @(posedge clk) begin
    if (w_push && !rst) r_mem[r_wr_ptr] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_unit_sc.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_unit_sc
// Description : Buffered UART transmitter. Bytes pushed into a sync_fifo are
//               serialized onto txd as LSB-first frames (8N1 by default).
//               Define UART_TX_PARITY_EN to insert an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_unit_sc
  import uart_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 86,
  parameter int DEPTH            = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] din,
  input  logic                   wr_en,
  output logic                   full,
  output logic                   empty,
  output logic                   busy,
  output logic                   txd
);

  localparam int BIT_CLKS = bit_clks(CLK_PER_HALF_BIT);
  localparam int CW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CLKS - 1);

  uart_tx_state_t         r_state;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_idx;
  logic [UART_DATA_W-1:0] r_shift;
  logic                   r_txd;
  logic                   r_busy;
`ifdef UART_TX_PARITY_EN
  logic                   r_parity;
`endif

  logic [UART_DATA_W-1:0] w_fifo_dout;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic                   w_bit_end;
  logic                   w_pop;

  assign w_bit_end = (r_cnt == CNT_LAST);
  // Pop from IDLE, or on the last STOP cycle so frames run back to back.
  assign w_pop = ~w_fifo_empty &
                 ((r_state == IDLE) | ((r_state == STOP) & w_bit_end));

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (UART_DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (w_pop),
    .din   (din),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // Serializer: sequences start, data, optional parity and stop bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_txd    <= 1'b1;
      r_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_txd <= 1'b1;
          if (w_pop) begin
            r_shift  <= w_fifo_dout;
`ifdef UART_TX_PARITY_EN
            r_parity <= ^w_fifo_dout;
`endif
            r_cnt    <= '0;
            r_state  <= START;
            r_txd    <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        START: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_state <= DATA;
            r_txd   <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DATA: begin
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_shift <= r_shift >> 1;
            if (r_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              r_state <= PARITY;
              r_txd   <= r_parity;
`else
              r_state <= STOP;
              r_txd   <= 1'b1;
`endif
            end else begin
              r_idx <= r_idx + 3'd1;
              r_txd <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        PARITY: begin
`ifdef UART_TX_PARITY_EN
          if (w_bit_end) begin
            r_cnt   <= '0;
            r_state <= STOP;
            r_txd   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
`else
          r_cnt   <= '0;
          r_state <= IDLE;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
`endif
        end
        STOP: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            if (w_pop) begin
              r_shift  <= w_fifo_dout;
`ifdef UART_TX_PARITY_EN
              r_parity <= ^w_fifo_dout;
`endif
              r_state  <= START;
              r_txd    <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_txd   <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
          r_txd   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign txd   = r_txd;
  assign busy  = r_busy;
  assign full  = w_fifo_full;
  assign empty = w_fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_unit_sc.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_unit_sc
// Description : Self-checking bench for uart_tx_unit_sc with a frame-level
//               reference model and a line-side receiver. Honours
//               UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_unit_sc;

  localparam int CPH   = 4;
  localparam int DEPTH = 4;
  localparam int BC    = 2 * CPH;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CLKS = NBITS * BC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       full, empty, busy, txd;

  always #5 clk = ~clk;

  uart_tx_unit_sc #(
    .CLK_PER_HALF_BIT (CPH),
    .DEPTH            (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .wr_en (wr_en),
    .full  (full),
    .empty (empty),
    .busy  (busy),
    .txd   (txd)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model: queue of bytes + frame position ------
  logic [7:0]  mq[$];
  logic [7:0]  exp_rx[$];
  int          pos = -1;
  logic [10:0] fbits;
  logic        m_txd = 1'b1;
  logic        m_busy = 1'b0;
  bit          m_valid = 0;
  bit          rx_abort = 0;
  int          m_sz;
  int          cyc = 0;

  function automatic logic [10:0] make_frame(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b11, b, 1'b0};
`endif
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete();
      exp_rx.delete();
      pos      = -1;
      m_txd    = 1'b1;
      m_busy   = 1'b0;
      m_valid  = 1;
      rx_abort = 1;
    end else begin
      m_sz = mq.size();
      if (pos == FRAME_CLKS - 1) pos = -1;
      else if (pos >= 0) pos++;
      if (pos == -1 && m_sz != 0) begin
        fbits = make_frame(mq.pop_front());
        pos   = 0;
      end
      if (wr_en && m_sz != DEPTH) begin
        mq.push_back(din);
        exp_rx.push_back(din);
      end
      m_txd  = (pos < 0) ? 1'b1 : fbits[pos / BC];
      m_busy = (pos >= 0);
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("txd",   txd,   m_txd);
      check("busy",  busy,  m_busy);
      check("empty", empty, mq.size() == 0);
      check("full",  full,  mq.size() == DEPTH);
    end
  end

  // ---------------- line-side receiver -------------------------------------
  bit          rx_on = 0;
  int          rx_t = 0;
  logic [10:0] rx_bits;
  logic [7:0]  rx_byte;
  logic        rx_last_par = 1'b0;
  int          rx_start[$];
  logic [7:0]  rx_log[$];

  always @(negedge clk) begin
    if (m_valid) begin
      if (rx_abort) begin
        rx_on    = 0;
        rx_abort = 0;
      end else begin
        if (!rx_on) begin
          if (txd === 1'b0) begin
            rx_on = 1;
            rx_t  = 0;
            rx_start.push_back(cyc);
          end
        end else begin
          rx_t++;
        end
        if (rx_on && (rx_t % BC) == BC / 2) begin
          rx_bits[rx_t / BC] = txd;
          if (rx_t / BC == NBITS - 1) begin
            rx_on   = 0;
            rx_byte = rx_bits[8:1];
            rx_log.push_back(rx_byte);
            check("rx_start_bit", rx_bits[0], 1'b0);
            check("rx_stop_bit", rx_bits[NBITS-1], 1'b1);
`ifdef UART_TX_PARITY_EN
            rx_last_par = rx_bits[9];
            check("rx_parity", rx_bits[9], ^rx_byte);
`endif
            check("rx_pending", exp_rx.size() > 0, 1'b1);
            if (exp_rx.size() > 0) check("rx_byte", rx_byte, exp_rx.pop_front());
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ---------------------------------------
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(busy === 1'b0 && empty === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < budget, 1'b1);
  endtask

  task automatic send_and_measure(input logic [7:0] b, output int len);
    int n;
    wr_en = 1'b1;
    din   = b;
    @(negedge clk);
    wr_en = 1'b0;
    n = 0;
    while (busy !== 1'b1 && n < 4) begin
      @(negedge clk);
      n++;
    end
    check("start_latency", n, 1);
    len = 0;
    while (busy === 1'b1 && len < 4 * FRAME_CLKS) begin
      @(negedge clk);
      len++;
    end
  endtask

  logic [7:0] a5 = 8'hA5;
  logic [7:0] ov [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic       w [FRAME_CLKS];
  int         bcnt, n0, len;
  logic [7:0] rb;

  initial begin
    // Reset
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_txd", txd, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    @(negedge clk);

    // Single byte 0xA5: latency and literal waveform
    wr_en = 1'b1;
    din   = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    check("lat_empty_after_push", empty, 1'b0);
    check("lat_txd_idle", txd, 1'b1);
    check("lat_busy_before_pop", busy, 1'b0);
    @(negedge clk);
    check("start_txd_low", txd, 1'b0);
    check("start_busy", busy, 1'b1);
    check("empty_after_pop", empty, 1'b1);
    bcnt = 0;
    for (int i = 0; i < FRAME_CLKS; i++) begin
      w[i] = txd;
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
    end
    check("busy_cycles", bcnt, FRAME_CLKS);
    check("busy_after_frame", busy, 1'b0);
    check("txd_after_frame", txd, 1'b1);
    check("a5_start_first", w[0], 1'b0);
    check("a5_start_last", w[BC-1], 1'b0);
    for (int k = 0; k < 8; k++)
      check($sformatf("a5_bit%0d", k), w[BC*(k+1) + BC/2], a5[k]);
`ifdef UART_TX_PARITY_EN
    check("a5_parity", w[9*BC + BC/2], 1'b0);
`endif
    check("a5_stop", w[FRAME_CLKS-1], 1'b1);

    // Back-to-back 0x00, 0xFF
    n0 = rx_start.size();
    wr_en = 1'b1;
    din   = 8'h00;
    @(negedge clk);
    din = 8'hFF;
    @(negedge clk);
    wr_en = 1'b0;
    wait_idle(4 * FRAME_CLKS);
    check("b2b_frames", rx_start.size() - n0, 2);
    if (rx_start.size() - n0 >= 2)
      check("b2b_spacing", rx_start[n0+1] - rx_start[n0], FRAME_CLKS);

    // Overflow: six pushes into a 4-deep FIFO while the first frame starts
    n0 = rx_log.size();
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1;
      din   = ov[i];
      @(negedge clk);
      if (i >= 4) check($sformatf("ov_full%0d", i), full, 1'b1);
    end
    wr_en = 1'b0;
    wait_idle(8 * FRAME_CLKS);
    check("ov_frames", rx_log.size() - n0, 5);
    for (int k = 0; k < 5; k++)
      if (n0 + k < rx_log.size()) check($sformatf("ov_byte%0d", k), rx_log[n0+k], ov[k]);

    // Reset during data bit 3 of 0x3C with two bytes queued
    wr_en = 1'b1;
    din   = 8'h3C;
    @(negedge clk);
    din = 8'hAA;
    @(negedge clk);
    din = 8'hBB;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (33) @(negedge clk);
    check("rst_mid_busy", busy, 1'b1);
    check("rst_mid_queued", empty, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_txd", txd, 1'b1);
    check("rst_mid_busy_low", busy, 1'b0);
    check("rst_mid_empty", empty, 1'b1);
    n0 = rx_start.size();
    repeat (3 * FRAME_CLKS) @(negedge clk);
    check("rst_no_frames", rx_start.size() - n0, 0);

    // Frame length and parity
    send_and_measure(8'h07, len);
    check("len_07", len, FRAME_CLKS);
`ifdef UART_TX_PARITY_EN
    check("par_07", rx_last_par, 1'b1);
    check("len_07_lit", len, 88);
`endif
    send_and_measure(8'h03, len);
    check("len_03", len, FRAME_CLKS);
`ifdef UART_TX_PARITY_EN
    check("par_03", rx_last_par, 1'b0);
`endif

    // Pointer wrap: nine single bytes through the 4-deep FIFO
    for (int i = 0; i < 9; i++) begin
      rb = 8'($urandom);
      send_and_measure(rb, len);
      check($sformatf("wrap_len%0d", i), len, FRAME_CLKS);
      if (rx_log.size() > 0) check($sformatf("wrap_byte%0d", i), rx_log[rx_log.size()-1], rb);
    end

    // Randomized push traffic, including pushes while full
    for (int i = 0; i < 3000; i++) begin
      wr_en = ($urandom_range(0, 3) == 0);
      din   = 8'($urandom);
      @(negedge clk);
    end
    wr_en = 1'b0;
    wait_idle((DEPTH + 2) * FRAME_CLKS);
    repeat (2) @(negedge clk);
    check("all_bytes_received", exp_rx.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
